// File: rtl/sat_accumulator_8bit.sv
// Frame accumulator: sums N_SAMPLES signed 8-bit samples through a lookahead adder,
// clamping or wrapping on signed overflow, and hands the result off via valid/ready.

// 8-bit carry-lookahead adder with signed overflow/underflow detection.
module cla_8bit_ovf_uvf (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       ovf,
  output logic       uvf
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded as a flat sum of generate terms gated by propagate chains.
  always_comb begin
    logic carry;
    logic prop;
    c     = '0;
    carry = 1'b0;
    prop  = 1'b0;
    c[0]  = cin;
    for (int i = 0; i < 8; i++) begin
      carry = g[i];
      prop  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry = carry | (prop & g[j]);
        prop  = prop & p[j];
      end
      carry    = carry | (prop & cin);
      c[i + 1] = carry;
    end
  end

  assign sum = p ^ c[7:0];
  // Same-sign operands whose sum flips sign mark overflow (positive) or underflow (negative).
  assign ovf = ~a[7] & ~b[7] &  sum[7];
  assign uvf =  a[7] &  b[7] & ~sum[7];

endmodule

module sat_accumulator_8bit #(
  parameter int unsigned N_SAMPLES = 16,
  parameter bit          SAT_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       ovf_flag,
  output logic       uvf_flag,
  output logic [7:0] sat_events,
  output logic       busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [DATA_W-1:0] POS_MAX = 8'h7F;
  localparam logic [DATA_W-1:0] NEG_MIN = 8'h80;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_SAMPLES - 1);
  localparam logic [7:0]        EV_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_flag_q, ovf_flag_d;
  logic              uvf_flag_q, uvf_flag_d;
  logic [7:0]        sat_events_q, sat_events_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] cla_sum;
  logic              cla_ovf;
  logic              cla_uvf;
  logic              accept;

  cla_8bit_ovf_uvf u_cla (
    .a   (acc_q),
    .b   (in_data),
    .cin (1'b0),
    .sum (cla_sum),
    .ovf (cla_ovf),
    .uvf (cla_uvf)
  );

  assign accept = (state_q == ACC) && in_valid;

  // Next-state, datapath update and registered handshake/status outputs.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_flag_d   = ovf_flag_q;
    uvf_flag_d   = uvf_flag_q;
    sat_events_d = sat_events_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d        = '0;
          cnt_d        = '0;
          ovf_flag_d   = 1'b0;
          uvf_flag_d   = 1'b0;
          sat_events_d = '0;
          state_d      = ACC;
        end
      end
      ACC: begin
        if (accept) begin
          if (SAT_EN && cla_ovf) begin
            acc_d = POS_MAX;
          end else if (SAT_EN && cla_uvf) begin
            acc_d = NEG_MIN;
          end else begin
            acc_d = cla_sum;
          end
          if (cla_ovf) ovf_flag_d = 1'b1;
          if (cla_uvf) uvf_flag_d = 1'b1;
          if ((cla_ovf || cla_uvf) && (sat_events_q != EV_MAX)) begin
            sat_events_d = sat_events_q + 8'd1;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered decodes of the upcoming state.
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_flag_q   <= 1'b0;
      uvf_flag_q   <= 1'b0;
      sat_events_q <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_flag_q   <= ovf_flag_d;
      uvf_flag_q   <= uvf_flag_d;
      sat_events_q <= sat_events_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = acc_q;
  assign ovf_flag   = ovf_flag_q;
  assign uvf_flag   = uvf_flag_q;
  assign sat_events = sat_events_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sat_accumulator_8bit.sv
// Bench for sat_accumulator_8bit: a saturating and a wrapping instance share stimulus.
`timescale 1ns/1ps
module tb_sat_accumulator_8bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       s_in_ready, s_out_valid, s_ovf, s_uvf, s_busy;
  logic [7:0] s_data, s_ev;
  logic       w_in_ready, w_out_valid, w_ovf, w_uvf, w_busy;
  logic [7:0] w_data, w_ev;

  int unsigned n_total;
  int unsigned n_pass;

  sat_accumulator_8bit #(.N_SAMPLES(16), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_data),
    .ovf_flag(s_ovf), .uvf_flag(s_uvf), .sat_events(s_ev), .busy(s_busy)
  );

  sat_accumulator_8bit #(.N_SAMPLES(16), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_data),
    .ovf_flag(w_ovf), .uvf_flag(w_uvf), .sat_events(w_ev), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #30 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    logic [7:0] sat_data;
    logic       sat_ovf;
    logic       sat_uvf;
    logic [7:0] sat_ev;
    logic [7:0] wr_data;
    logic       wr_ovf;
    logic       wr_uvf;
    logic [7:0] wr_ev;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one sample for n consecutive accepted cycles.
  task automatic feed(input logic [7:0] v, input int n);
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < n; k++) tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic release_done(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_out_valid"}, 32'(s_out_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(s_busy), 32'd0);
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    //           v      sat: data ovf  uvf  ev     wrap: data ovf  uvf  ev
    tbl[0] = '{8'h01, 8'h10, 1'b0, 1'b0, 8'd0,  8'h10, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{8'h64, 8'h7F, 1'b1, 1'b0, 8'd15, 8'h40, 1'b1, 1'b0, 8'd6};
    tbl[2] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'd15, 8'h00, 1'b0, 1'b1, 8'd8};
    tbl[3] = '{8'hFF, 8'hF0, 1'b0, 1'b0, 8'd0,  8'hF0, 1'b0, 1'b0, 8'd0};
    tbl[4] = '{8'h08, 8'h7F, 1'b1, 1'b0, 8'd1,  8'h80, 1'b1, 1'b0, 8'd1};

    tick();
    tick();
    chk("rst_in_ready", 32'(s_in_ready), 32'd0);
    chk("rst_out_valid", 32'(s_out_valid), 32'd0);
    chk("rst_out_data", 32'(s_data), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Uniform-sample frames: 16 copies of one value each.
    for (int t = 0; t < 5; t++) begin
      do_start();
      chk($sformatf("v%0d_in_ready", t), 32'(s_in_ready), 32'd1);
      chk($sformatf("v%0d_busy", t), 32'(s_busy), 32'd1);
      feed(tbl[t].v, 15);
      chk($sformatf("v%0d_early_valid", t), 32'(s_out_valid), 32'd0);
      feed(tbl[t].v, 1);
      chk($sformatf("v%0d_out_valid", t), 32'(s_out_valid), 32'd1);
      chk($sformatf("v%0d_done_in_ready", t), 32'(s_in_ready), 32'd0);
      chk($sformatf("v%0d_sat_data", t), 32'(s_data), 32'(tbl[t].sat_data));
      chk($sformatf("v%0d_sat_ovf", t), 32'(s_ovf), 32'(tbl[t].sat_ovf));
      chk($sformatf("v%0d_sat_uvf", t), 32'(s_uvf), 32'(tbl[t].sat_uvf));
      chk($sformatf("v%0d_sat_ev", t), 32'(s_ev), 32'(tbl[t].sat_ev));
      chk($sformatf("v%0d_wr_valid", t), 32'(w_out_valid), 32'd1);
      chk($sformatf("v%0d_wr_data", t), 32'(w_data), 32'(tbl[t].wr_data));
      chk($sformatf("v%0d_wr_ovf", t), 32'(w_ovf), 32'(tbl[t].wr_ovf));
      chk($sformatf("v%0d_wr_uvf", t), 32'(w_uvf), 32'(tbl[t].wr_uvf));
      chk($sformatf("v%0d_wr_ev", t), 32'(w_ev), 32'(tbl[t].wr_ev));
      release_done($sformatf("v%0d", t));
    end

    // Overflow recovery: +127, +1 clamps, -1 steps back down, then zeros.
    do_start();
    feed(8'h7F, 1);
    feed(8'h01, 1);
    feed(8'hFF, 1);
    feed(8'h00, 13);
    chk("rec_out_valid", 32'(s_out_valid), 32'd1);
    chk("rec_data", 32'(s_data), 32'h7E);
    chk("rec_ovf", 32'(s_ovf), 32'd1);
    chk("rec_uvf", 32'(s_uvf), 32'd0);
    chk("rec_ev", 32'(s_ev), 32'd1);
    chk("rec_wr_data", 32'(w_data), 32'h7F);
    chk("rec_wr_uvf", 32'(w_uvf), 32'd1);
    // Downstream stalls; in_data is driven but must be ignored.
    in_data = 8'h55;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold%0d_valid", k), 32'(s_out_valid), 32'd1);
      chk($sformatf("hold%0d_data", k), 32'(s_data), 32'h7E);
      chk($sformatf("hold%0d_in_ready", k), 32'(s_in_ready), 32'd0);
      chk($sformatf("hold%0d_ovf", k), 32'(s_ovf), 32'd1);
    end
    in_valid = 1'b0;
    // start coinciding with out_ready must not open a new frame.
    start = 1'b1;
    release_done("rec");
    start = 1'b0;
    tick();
    chk("rec_start_ignored_busy", 32'(s_busy), 32'd0);
    chk("rec_start_ignored_ready", 32'(s_in_ready), 32'd0);

    // Mid-frame reset after 7 accepts that already set ovf.
    do_start();
    feed(8'h64, 7);
    chk("pre_rst_ovf", 32'(s_ovf), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mrst_in_ready", 32'(s_in_ready), 32'd0);
    chk("mrst_out_valid", 32'(s_out_valid), 32'd0);
    chk("mrst_data", 32'(s_data), 32'd0);
    chk("mrst_ovf", 32'(s_ovf), 32'd0);
    chk("mrst_uvf", 32'(s_uvf), 32'd0);
    chk("mrst_ev", 32'(s_ev), 32'd0);
    chk("mrst_busy", 32'(s_busy), 32'd0);
    rst_n = 1'b1;
    tick();
    do_start();
    feed(8'h02, 16);
    chk("post_rst_valid", 32'(s_out_valid), 32'd1);
    chk("post_rst_data", 32'(s_data), 32'h20);
    chk("post_rst_ev", 32'(s_ev), 32'd0);
    release_done("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
